dual_operand_engine: RTL and testbench

DUAL_OPERAND_ENGINE -- requirements
Module: dual_operand_engine

---
 rtl/dual_operand_engine.sv | 176 +++++++++++++++++
 tb/tb_dual_operand_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_operand_engine.sv
// dual_operand_engine
//
// Two-operand arithmetic engine with valid/ready handshakes on both sides.
// An operand pair (signal_1 = A, signal_2 = B) and an op code are captured,
// the result is computed in a single CALC cycle, and the result is then held
// on signal_3/overflow until the consumer takes it.
//
//   op = 00  ADD : signal_3 = A + B,        overflow = carry out
//   op = 01  SUB : signal_3 = A - B,        overflow = (A < B)
//   op = 10  MAX : signal_3 = max(A, B),    overflow = 0
//   op = 11  ACC : acc = acc + A,           signal_3 = new acc, overflow = carry
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds its payload stable
// while valid=1 and ready=0. in_ready may depend combinationally on out_ready
// (in HOLD), so a result can be delivered and a new pair accepted on the
// same edge.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        asynchronous active-low reset
//   in_valid   operand pair / op valid
//   in_ready   engine can accept operands
//   signal_1   operand A
//   signal_2   operand B
//   op         operation select, captured together with the operands
//   signal_3   registered result
//   out_valid  signal_3 / overflow valid
//   out_ready  consumer accepts the result
//   overflow   registered carry / borrow flag of the result
//   txn_count  number of completed output transfers (wraps)
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 HOLD)

module dual_operand_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] signal_1,
  input  logic [DATA_WIDTH-1:0] signal_2,
  input  logic [1:0]            op,
  output logic [DATA_WIDTH-1:0] signal_3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  txn_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  // Goes high on the first edge after reset release; keeps in_ready low
  // until then so nothing is accepted on the deassertion itself.
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // One extra bit on each arithmetic path carries the carry / borrow.
  logic [DATA_WIDTH:0]   sum_w;
  logic [DATA_WIDTH:0]   diff_w;
  logic [DATA_WIDTH:0]   acc_sum_w;

  assign sum_w     = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w    = {1'b0, a_q} - {1'b0, b_q};
  assign acc_sum_w = {1'b0, acc_q} + {1'b0, a_q};

  always_comb begin
    state_d   = state_q;
    en_d      = 1'b1;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    ov_d      = ov_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = en_q;
        if (in_valid && en_q) begin
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        state_d = S_HOLD;
        case (op_q)
          2'b00: begin
            res_d = sum_w[DATA_WIDTH-1:0];
            ov_d  = sum_w[DATA_WIDTH];
          end
          2'b01: begin
            // The borrow out of the widened subtraction is exactly A < B.
            res_d = diff_w[DATA_WIDTH-1:0];
            ov_d  = diff_w[DATA_WIDTH];
          end
          2'b10: begin
            res_d = (a_q > b_q) ? a_q : b_q;
            ov_d  = 1'b0;
          end
          default: begin
            acc_d = acc_sum_w[DATA_WIDTH-1:0];
            res_d = acc_sum_w[DATA_WIDTH-1:0];
            ov_d  = acc_sum_w[DATA_WIDTH];
          end
        endcase
      end

      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = in_valid ? S_CALC : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Operand capture on any input transfer (from IDLE or from HOLD).
    if (in_valid && in_ready) begin
      a_d  = signal_1;
      b_d  = signal_2;
      op_d = op;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      res_q   <= '0;
      ov_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign signal_3  = res_q;
  assign overflow  = ov_q;
  assign txn_count = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dual_operand_engine.sv
// Testbench for dual_operand_engine (DATA_WIDTH=8, CNT_WIDTH=16).
// Inputs are driven 1ns after the rising edge; outputs are sampled at the
// same point, well away from the active edge.

module tb_dual_operand_engine;

  localparam int DW = 8;
  localparam int CW = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] signal_1;
  logic [DW-1:0] signal_2;
  logic [1:0]    op;
  logic [DW-1:0] signal_3;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic [CW-1:0] txn_count;
  logic [1:0]    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dual_operand_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .signal_1  (signal_1),
    .signal_2  (signal_2),
    .op        (op),
    .signal_3  (signal_3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .txn_count (txn_count),
    .dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_txn  = 0;
  logic [DW:0]   exp_q[$];   // {overflow, signal_3}

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // One complete transaction with out_ready=1: accept, CALC, HOLD, deliver.
  task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] o, input logic [DW-1:0] er,
                         input logic eov, input string nm);
    int waited;
    waited    = 0;
    signal_1  = a;
    signal_2  = b;
    op        = o;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk({nm, "_in_ready"}, in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    tick();                       // accept edge N
    in_valid = 1'b0;
    chk({nm, "_calc_valid"}, out_valid, 0);
    chk({nm, "_calc_state"}, dbg_state, ST_CALC);
    tick();                       // edge N+1: result registered
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_signal_3"}, signal_3, er);
    chk({nm, "_overflow"}, overflow, eov);
    tick();                       // edge N+2: output transfer
    exp_txn++;
    chk({nm, "_txn_count"}, txn_count, exp_txn);
    chk({nm, "_idle"}, dbg_state, ST_IDLE);
  endtask

  task automatic release_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({nm, "_ready_before_edge"}, in_ready, 0);
    tick();
    chk({nm, "_ready_after_edge"}, in_ready, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    o;
    logic [DW-1:0] res;
    logic          ov;
    string         name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [DW-1:0] sa, sb;
    logic [DW:0]   got, want;

    vecs[0]  = '{8'hF0, 8'h20, 2'b00, 8'h10, 1'b1, "add_wrap"};
    vecs[1]  = '{8'h05, 8'h07, 2'b01, 8'hFE, 1'b1, "sub_borrow"};
    vecs[2]  = '{8'h33, 8'h80, 2'b10, 8'h80, 1'b0, "max_b"};
    vecs[3]  = '{8'h12, 8'h34, 2'b00, 8'h46, 1'b0, "add_plain"};
    vecs[4]  = '{8'h80, 8'h01, 2'b01, 8'h7F, 1'b0, "sub_plain"};
    vecs[5]  = '{8'h07, 8'h07, 2'b01, 8'h00, 1'b0, "sub_equal"};
    vecs[6]  = '{8'hFF, 8'h00, 2'b10, 8'hFF, 1'b0, "max_a"};
    vecs[7]  = '{8'h10, 8'h10, 2'b10, 8'h10, 1'b0, "max_equal"};
    vecs[8]  = '{8'h90, 8'h55, 2'b11, 8'h90, 1'b0, "acc_1"};
    vecs[9]  = '{8'h90, 8'hAA, 2'b11, 8'h20, 1'b1, "acc_2"};
    vecs[10] = '{8'h01, 8'h33, 2'b11, 8'h21, 1'b0, "acc_3"};
    vecs[11] = '{8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, "add_to_zero"};
    vecs[12] = '{8'hFF, 8'hFF, 2'b00, 8'hFE, 1'b1, "add_max"};

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    signal_1  = '0;
    signal_2  = '0;
    op        = 2'b00;

    // ---- reset state ----
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_signal_3", signal_3, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);
    release_reset("rst1");

    // out_ready while nothing is valid must not count a transfer
    out_ready = 1'b1;
    tick();
    tick();
    chk("idle_out_ready_txn", txn_count, 0);

    // ---- table-driven single transactions ----
    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].res, vecs[i].ov, vecs[i].name);
    end

    // ---- backpressure in HOLD with in_valid held high ----
    signal_1  = 8'h01;
    signal_2  = 8'h02;
    op        = 2'b00;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    tick();                       // accept 01+02
    signal_1 = 8'h10;
    signal_2 = 8'h20;
    tick();                       // HOLD
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_signal_3", signal_3, 8'h03);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_txn_count", txn_count, exp_txn);
      signal_1 = 8'($urandom_range(0, 255));
      signal_2 = 8'($urandom_range(0, 255));
      op       = 2'($urandom_range(0, 3));
      tick();
    end
    chk("bp_signal_3_end", signal_3, 8'h03);
    signal_1  = 8'h10;
    signal_2  = 8'h20;
    op        = 2'b00;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_follows", in_ready, 1);
    tick();                       // transfer + capture on the same edge
    in_valid = 1'b0;
    exp_txn++;
    chk("bp_txn_after", txn_count, exp_txn);
    chk("bp_calc_valid", out_valid, 0);
    chk("bp_calc_state", dbg_state, ST_CALC);
    tick();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_signal_3", signal_3, 8'h30);
    chk("bp_next_overflow", overflow, 0);
    tick();
    exp_txn++;
    chk("bp_next_txn", txn_count, exp_txn);
    chk("bp_next_idle", dbg_state, ST_IDLE);

    // ---- reset during CALC of an ACC transaction ----
    signal_1  = 8'h40;
    signal_2  = 8'h00;
    op        = 2'b11;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("mid_idle_ready", in_ready, 1);
    tick();
    chk("mid_in_calc", dbg_state, ST_CALC);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_signal_3", signal_3, 0);
    chk("mid_overflow", overflow, 0);
    chk("mid_txn_count", txn_count, 0);
    chk("mid_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    release_reset("rst2");
    exp_txn = 0;
    run_txn(8'h01, 8'hEE, 2'b11, 8'h01, 1'b0, "acc_after_rst");

    // ---- back-to-back streaming from a fresh reset ----
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst3_txn_count", txn_count, 0);
    repeat (2) @(posedge clk);
    release_reset("rst3");
    exp_txn   = 0;
    out_ready = 1'b1;
    op        = 2'b00;
    sa        = 8'h05;
    sb        = 8'hC8;
    signal_1  = sa;
    signal_2  = sb;
    exp_q.push_back({1'b0, sa} + {1'b0, sb});
    in_valid  = 1'b1;
    tick();                       // first accept
    for (int k = 0; k < 10; k++) begin
      chk("stream_calc_valid", out_valid, 0);
      tick();
      chk("stream_out_valid", out_valid, 1);
      got  = {overflow, signal_3};
      want = exp_q.pop_front();
      chk("stream_result", got, want);
      if (k < 9) begin
        sa       = 8'(sa + 8'd37);
        sb       = 8'(sb + 8'd91);
        signal_1 = sa;
        signal_2 = sb;
        exp_q.push_back({1'b0, sa} + {1'b0, sb});
      end else begin
        in_valid = 1'b0;
      end
      chk("stream_in_ready", in_ready, 1);
      tick();
    end
    chk("stream_txn_count", txn_count, 10);
    chk("stream_idle", dbg_state, ST_IDLE);
    chk("stream_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
